// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine in front of a unified,
// word-addressed memory (combinational read, synchronous write).
// Sub-word stores use read-modify-write. Loads support byte/half sign or zero extension.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests complete
// immediately with err=1 and no memory access. Without it, the low address bits are ignored.
module mem_access_unit #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          ready,
   output logic          done,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rd
);

   localparam int unsigned LW = 8;
   localparam int unsigned HW = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic            we_q;
   logic            signed_q;
   logic [1:0]      size_q;
   logic [AW-1:0]   addr_q;
   logic [HW-1:0]   wdata_q;

   logic            ready_nxt;
   logic            done_nxt;
   logic            err_nxt;
   logic            mem_we_nxt;
   logic [DW-1:0]   mem_wd_nxt;
   logic [DW-1:0]   rdata_nxt;
   logic            trap_c;

   // Select the addressed lane(s) of a memory word and extend to 32 bits
   function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w,
                                              input logic [1:0]    sz,
                                              input logic          sg,
                                              input logic [1:0]    off);
      logic [LW-1:0] b;
      logic [HW-1:0] h;
      logic [DW-1:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = {{(DW-LW){sg & b[LW-1]}}, b};
         2'b01:   r = {{(DW-HW){sg & h[HW-1]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace the addressed byte or half of an existing word with new store data
   function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0] w,
                                                input logic          is_half,
                                                input logic [1:0]    off,
                                                input logic [HW-1:0] d);
      logic [DW-1:0] r;
      r = w;
      if (is_half) begin
         if (off[1]) r[31:16] = d;
         else        r[15:0]  = d;
      end else begin
         case (off)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end
      return r;
   endfunction

`ifdef MISALIGN_TRAP_EN
   // Misaligned half (odd address) or word (non-zero offset) request
   always_comb begin
      trap_c = ((req_size == 2'b01) && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
   end
`else
   // Misalignment is never trapped; low address bits are simply ignored
   always_comb begin
      trap_c = 1'b0;
   end
`endif

   // Memory is always addressed on the word containing the registered address
   assign mem_addr = {addr_q[AW-1:2], 2'b00};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) state_nxt = trap_c ? DONE : ACCESS;
         end
         ACCESS: begin
            if (we_q && !size_q[1]) state_nxt = WRITE;
            else                    state_nxt = DONE;
         end
         WRITE:   state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      ready_nxt  = (state_nxt == IDLE);
      done_nxt   = (state_nxt == DONE);
      err_nxt    = 1'b0;
      mem_we_nxt = 1'b0;
      mem_wd_nxt = mem_wd;
      rdata_nxt  = rdata;
      case (state)
         IDLE: begin
            if (req) begin
               if (trap_c) begin
                  err_nxt = 1'b1;
               end else if (req_we && req_size[1]) begin
                  mem_we_nxt = 1'b1;
                  mem_wd_nxt = req_wdata;
               end
            end
         end
         ACCESS: begin
            if (!we_q) begin
               rdata_nxt = load_ext(mem_rd, size_q, signed_q, addr_q[1:0]);
            end else if (!size_q[1]) begin
               // merged read-modify-write word is registered straight into mem_wd
               mem_we_nxt = 1'b1;
               mem_wd_nxt = merge_lane(mem_rd, size_q[0], addr_q[1:0], wdata_q);
            end
         end
         default: ;
      endcase
   end

   // Request capture and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready    <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         mem_we   <= 1'b0;
         mem_wd   <= '0;
         rdata    <= '0;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         ready  <= ready_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
         mem_we <= mem_we_nxt;
         mem_wd <= mem_wd_nxt;
         rdata  <= rdata_nxt;
         if ((state == IDLE) && req) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[HW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .ready(ready), .done(done), .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
   end

   // Issue one request in an idle cycle and watch until done (bounded)
   task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int wep, output logic [31:0] wd_s, output logic [31:0] wa_s);
      @(negedge clk);
      req = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req = 1'b0;
      lat = -1; rd = '0; er = 1'b0; wep = 0; wd_s = '0; wa_s = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_we) begin
            wep++;
            wd_s = mem_wd;
            wa_s = mem_addr;
         end
         if (done) begin
            lat = c;
            rd  = rdata;
            er  = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%08h exp=00000000", rdata); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%08h exp=00000000", mem_addr); end
      total++; if (mem_wd !== 32'h0) begin bad++; $display("FAIL reset_mem_wd got=%08h exp=00000000", mem_wd); end
   endtask

   task automatic test_loads();
      logic [31:0] va [10];
      logic [1:0]  vs [10];
      logic        vg [10];
      logic [31:0] ve [10];
      int lat, wep; logic [31:0] rd, wd_s, wa_s; logic er;
      va = '{32'h41, 32'h41, 32'h40, 32'h43, 32'h42, 32'h42, 32'h40, 32'h40, 32'h40, 32'h40};
      vs = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
      vg = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
      ve = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFFFBB, 32'hFFFFFF88, 32'h00000099,
             32'hFFFF8899, 32'hFFFFAABB, 32'h0000AABB, 32'h8899AABB, 32'h8899AABB};
      mem[8'h10] = 32'h8899AABB;
      for (int i = 0; i < 10; i++) begin
         run_req(1'b0, vs[i], vg[i], va[i], 32'h0, lat, rd, er, wep, wd_s, wa_s);
         total++; if (rd !== ve[i]) begin bad++; $display("FAIL load%0d_rdata got=%08h exp=%08h", i, rd, ve[i]); end
         total++; if (lat != 2) begin bad++; $display("FAIL load%0d_latency got=%0d exp=2", i, lat); end
         total++; if (er !== 1'b0 || wep != 0) begin bad++; $display("FAIL load%0d_err_we got=%0h/%0d exp=0/0", i, er, wep); end
      end
   endtask

   task automatic test_sub_store();
      int lat, wep; logic [31:0] rd, wd_s, wa_s; logic er;
      mem[8'h10] = 32'h8899AABB;
      // rdata still holds the last word load (8899AABB) and must survive stores
      run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF1234, lat, rd, er, wep, wd_s, wa_s);
      total++; if (lat != 3) begin bad++; $display("FAIL half_store_latency got=%0d exp=3", lat); end
      total++; if (wep != 1) begin bad++; $display("FAIL half_store_we_pulses got=%0d exp=1", wep); end
      total++; if (wd_s !== 32'h1234AABB) begin bad++; $display("FAIL half_store_mem_wd got=%08h exp=1234AABB", wd_s); end
      total++; if (mem[8'h10] !== 32'h1234AABB) begin bad++; $display("FAIL half_store_mem got=%08h exp=1234AABB", mem[8'h10]); end
      total++; if (rd !== 32'h8899AABB) begin bad++; $display("FAIL store_keeps_rdata got=%08h exp=8899AABB", rd); end
      run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, wep, wd_s, wa_s);
      total++; if (rd !== 32'h1234AABB) begin bad++; $display("FAIL half_store_readback got=%08h exp=1234AABB", rd); end
      run_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000AB55, lat, rd, er, wep, wd_s, wa_s);
      total++; if (wd_s !== 32'h123455BB || lat != 3) begin bad++; $display("FAIL byte1_store got=%08h/%0d exp=123455BB/3", wd_s, lat); end
      run_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h0000007E, lat, rd, er, wep, wd_s, wa_s);
      total++; if (wd_s !== 32'h7E3455BB || wep != 1) begin bad++; $display("FAIL byte3_store got=%08h/%0d exp=7E3455BB/1", wd_s, wep); end
      run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, wep, wd_s, wa_s);
      total++; if (rd !== 32'h7E3455BB) begin bad++; $display("FAIL byte_store_readback got=%08h exp=7E3455BB", rd); end
   endtask

   task automatic test_word_store();
      int lat, wep; logic [31:0] rd, wd_s, wa_s; logic er;
      run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, lat, rd, er, wep, wd_s, wa_s);
      total++; if (lat != 2) begin bad++; $display("FAIL word_store_latency got=%0d exp=2", lat); end
      total++; if (wep != 1) begin bad++; $display("FAIL word_store_we_pulses got=%0d exp=1", wep); end
      total++; if (wa_s !== 32'h80) begin bad++; $display("FAIL word_store_addr got=%08h exp=00000080", wa_s); end
      total++; if (wd_s !== 32'hDEADBEEF) begin bad++; $display("FAIL word_store_wd got=%08h exp=DEADBEEF", wd_s); end
      run_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, rd, er, wep, wd_s, wa_s);
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_store_readback got=%08h exp=DEADBEEF", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got [3];
      int          got_cyc [3];
      logic [31:0] exp_v [3];
      int          exp_c [3];
      int n_done;
      exp_v = '{32'h11111111, 32'h44444444, 32'h77777777};
      exp_c = '{2, 5, 8};
      for (int k = 0; k < 7; k++) mem[8'h40 + 8'(k)] = 32'h11111111 * 32'(k + 1);
      n_done = 0;
      for (int i = 0; i < 3; i++) begin got[i] = '0; got_cyc[i] = -1; end
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (done) begin
            if (n_done < 3) begin got[n_done] = rdata; got_cyc[n_done] = n; end
            n_done++;
         end
         if (n < 7) begin
            req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
            req_addr = 32'h100 + 32'(4 * n);
         end else begin
            req = 1'b0;
         end
      end
      total++; if (n_done != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", n_done); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (got[i] !== exp_v[i] || got_cyc[i] != exp_c[i]) begin
            bad++;
            $display("FAIL b2b_req%0d got=%08h@%0d exp=%08h@%0d", i, got[i], got_cyc[i], exp_v[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      mem[8'h08] = 32'hCAFEF00D;
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h77;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL abort_write_pending got=%0h exp=1", mem_we); end
      reset = 1'b1;
      #1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL abort_mem_we got=%0h exp=0", mem_we); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      total++; if (mem[8'h08] !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_mem_unchanged got=%08h exp=CAFEF00D", mem[8'h08]); end
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0h exp=1", ready); end
   endtask

   task automatic test_misalign();
      int lat, wep; logic [31:0] rd, wd_s, wa_s; logic er;
      mem[8'h10] = 32'h8899AABB;
      run_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, rd, er, wep, wd_s, wa_s);
      total++; if (rd !== 32'h000000BB) begin bad++; $display("FAIL misalign_setup got=%08h exp=000000BB", rd); end
      run_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, er, wep, wd_s, wa_s);
`ifdef MISALIGN_TRAP_EN
      total++; if (lat != 1 || er !== 1'b1) begin bad++; $display("FAIL mis_word_trap got=%0d/%0h exp=1/1", lat, er); end
      total++; if (wep != 0 || rd !== 32'h000000BB) begin bad++; $display("FAIL mis_word_side got=%0d/%08h exp=0/000000BB", wep, rd); end
`else
      total++; if (lat != 2 || er !== 1'b0) begin bad++; $display("FAIL mis_word_lat_err got=%0d/%0h exp=2/0", lat, er); end
      total++; if (rd !== 32'h8899AABB) begin bad++; $display("FAIL mis_word_rdata got=%08h exp=8899AABB", rd); end
`endif
      run_req(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, lat, rd, er, wep, wd_s, wa_s);
`ifdef MISALIGN_TRAP_EN
      total++; if (lat != 1 || er !== 1'b1 || rd !== 32'h000000BB) begin bad++; $display("FAIL mis_half_trap got=%0d/%0h/%08h exp=1/1/000000BB", lat, er, rd); end
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL mis_err_one_cycle got=%0h exp=0", err); end
`else
      total++; if (lat != 2 || er !== 1'b0 || rd !== 32'hFFFFAABB) begin bad++; $display("FAIL mis_half got=%0d/%0h/%08h exp=2/0/FFFFAABB", lat, er, rd); end
`endif
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_loads();
      test_sub_store();
      test_word_store();
      test_back_to_back();
      test_reset_abort();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
